oam_motion_sequencer: RTL and testbench

Frame-synchronous OAM feeder in the CLOCK_50 domain, directly upstream of the `ppu` CPU-side OAM port (`cpu_oam_data`, `cpu_oam_addr`, `cpu_write`). It holds a shadow table of up to 64 sprites, each with a position, tile, palette and signed velocity. Once per video frame it advances every sprite's position with wrap-around, and streams the updated OAM words to the PPU. Each write strobe is stretched so the PPU, clocked at 25 MHz, always samples it.

---
 rtl/oam_motion_sequencer_if.sv | 18 +
 rtl/oam_motion_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_oam_motion_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/oam_motion_sequencer_if.sv
// CPU-side OAM write port between the motion sequencer (master) and the PPU (slave).
interface oam_motion_sequencer_if;
  logic [31:0] cpu_oam_data;
  logic [5:0]  cpu_oam_addr;
  logic        cpu_write;

  modport master (
    output cpu_oam_data,
    output cpu_oam_addr,
    output cpu_write
  );

  modport slave (
    input cpu_oam_data,
    input cpu_oam_addr,
    input cpu_write
  );
endinterface

// File: rtl/oam_motion_sequencer.sv
// Per-frame sprite mover: advances a shadow sprite table on each vblank and streams OAM words to the PPU.
// Define OAM_SEQ_BOUNCE_EN to make sprites reflect off the screen edges instead of wrapping.
module oam_motion_sequencer #(
  parameter int NUM_SPRITES = 4,
  parameter int X_MAX       = 248,
  parameter int Y_MAX       = 224
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  vblank,
  input  logic                  cfg_we,
  input  logic [5:0]            cfg_idx,
  input  logic [31:0]           cfg_data,
  input  logic [7:0]            cfg_vel,
  oam_motion_sequencer_if.master oam,
  output logic                  busy,
  output logic                  overrun,
  output logic [15:0]           frame_count
);

  localparam int EW = 40;
  localparam logic [5:0]        LAST_IDX = 6'(NUM_SPRITES - 1);
  localparam logic signed [9:0] X_LIM    = 10'(X_MAX);
  localparam logic signed [9:0] Y_LIM    = 10'(Y_MAX);

  typedef struct packed {
    logic [7:0] pal;
    logic [7:0] tile;
    logic [7:0] y;
    logic [7:0] x;
    logic [3:0] dy;
    logic [3:0] dx;
  } entry_t;

  typedef enum logic [1:0] {IDLE, LOAD, ASSERT, GAP} state_t;

`ifdef OAM_SEQ_BOUNCE_EN
  // -(-8) does not fit in 4 bits, so the fastest negative speed reflects to +7.
  function automatic logic [3:0] flip(input logic [3:0] v);
    return (v == 4'b1000) ? 4'b0111 : (~v + 4'd1);
  endfunction
`endif

  // Returns {new_velocity, new_position} for one axis.
  function automatic logic [11:0] advance(input logic [7:0] p, input logic [3:0] v,
                                          input logic signed [9:0] lim);
    logic signed [9:0] s;
    logic [7:0]        pn;
    logic [3:0]        vn;
    s  = $signed({2'b00, p}) + $signed({{6{v[3]}}, v});
    vn = v;
`ifdef OAM_SEQ_BOUNCE_EN
    pn = s[7:0];
    if (s > lim) begin
      pn = lim[7:0];
      vn = flip(v);
    end else if (s < 10'sd0) begin
      pn = 8'd0;
      vn = flip(v);
    end
`else
    if (s > lim)
      s = s - (lim + 10'sd1);
    else if (s < 10'sd0)
      s = s + (lim + 10'sd1);
    pn = s[7:0];
`endif
    return {vn, pn};
  endfunction

  logic        sync1_reg, sync2_reg, sync3_reg, tick_reg;
  state_t      state_reg;
  logic [5:0]  k_reg;
  logic        phase_reg;
  logic [31:0] data_reg;
  logic [5:0]  addr_reg;
  logic        write_reg;
  logic        busy_reg;
  logic        overrun_reg;
  logic [15:0] frame_count_reg;

  wire [NUM_SPRITES*EW-1:0] tab_flat;
  entry_t                   cur;
  entry_t                   upd;
  logic [11:0]              x_next;
  logic [11:0]              y_next;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      sync1_reg <= vblank;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
      tick_reg  <= sync2_reg & ~sync3_reg;
    end
  end

  // Shadow table; a cfg write beats the LOAD write-back to the same entry.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_ent
      entry_t ent_reg;
      always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
          ent_reg <= '0;
        else if (cfg_we && cfg_idx == 6'(gi))
          ent_reg <= {cfg_data, cfg_vel};
        else if (state_reg == LOAD && k_reg == 6'(gi))
          ent_reg <= upd;
      end
      assign tab_flat[gi*EW +: EW] = ent_reg;
    end
  endgenerate

  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_SPRITES; i++)
      if (k_reg == 6'(i)) cur = tab_flat[i*EW +: EW];
    x_next = advance(cur.x, cur.dx, X_LIM);
    y_next = advance(cur.y, cur.dy, Y_LIM);
    upd    = cur;
    upd.x  = x_next[7:0];
    upd.dx = x_next[11:8];
    upd.y  = y_next[7:0];
    upd.dy = y_next[11:8];
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      k_reg           <= '0;
      phase_reg       <= 1'b0;
      data_reg        <= '0;
      addr_reg        <= '0;
      write_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      overrun_reg     <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (tick_reg) begin
            state_reg       <= LOAD;
            k_reg           <= '0;
            busy_reg        <= 1'b1;
            frame_count_reg <= frame_count_reg + 16'd1;
          end
        end
        LOAD: begin
          addr_reg  <= k_reg;
          data_reg  <= {cur.pal, cur.tile, upd.y, upd.x};
          write_reg <= 1'b1;
          phase_reg <= 1'b0;
          state_reg <= ASSERT;
        end
        ASSERT: begin
          if (phase_reg) begin
            write_reg <= 1'b0;
            phase_reg <= 1'b0;
            state_reg <= GAP;
          end else begin
            phase_reg <= 1'b1;
          end
        end
        GAP: begin
          if (phase_reg) begin
            phase_reg <= 1'b0;
            if (k_reg == LAST_IDX) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              k_reg     <= k_reg + 6'd1;
              state_reg <= LOAD;
            end
          end else begin
            phase_reg <= 1'b1;
          end
        end
      endcase
      if (tick_reg && state_reg != IDLE)
        overrun_reg <= 1'b1;
    end
  end

  assign oam.cpu_oam_data = data_reg;
  assign oam.cpu_oam_addr = addr_reg;
  assign oam.cpu_write    = write_reg;
  assign busy             = busy_reg;
  assign overrun          = overrun_reg;
  assign frame_count      = frame_count_reg;

endmodule

// File: tb/tb_oam_motion_sequencer.sv
// Directed bench for oam_motion_sequencer with two sprites; expectations follow OAM_SEQ_BOUNCE_EN when defined.
module tb_oam_motion_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vblank = 1'b0;
  logic        cfg_we = 1'b0;
  logic [5:0]  cfg_idx = '0;
  logic [31:0] cfg_data = '0;
  logic [7:0]  cfg_vel = '0;
  logic        busy;
  logic        overrun;
  logic [15:0] frame_count;

  oam_motion_sequencer_if bus();

  oam_motion_sequencer #(.NUM_SPRITES(2), .X_MAX(248), .Y_MAX(224)) dut (
    .CLOCK_50   (clk),
    .reset_n    (reset_n),
    .vblank     (vblank),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_data   (cfg_data),
    .cfg_vel    (cfg_vel),
    .oam        (bus),
    .busy       (busy),
    .overrun    (overrun),
    .frame_count(frame_count)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int hi_len = 0;
  logic wr_prev = 1'b0;
  logic [5:0]  addr_q[$];
  logic [31:0] data_q[$];
  int          len_q[$];
  int          rise_q[$];

  // Write-port monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.cpu_write) begin
      if (!wr_prev) begin
        addr_q.push_back(bus.cpu_oam_addr);
        data_q.push_back(bus.cpu_oam_data);
        rise_q.push_back(cyc);
        hi_len = 0;
      end
      hi_len++;
    end else if (wr_prev) begin
      len_q.push_back(hi_len);
    end
    if (busy) busy_cnt++;
    wr_prev = bus.cpu_write;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [5:0] idx, input logic [31:0] data, input logic [7:0] vel);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = idx; cfg_data = data; cfg_vel = vel;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic clear_mon();
    addr_q.delete(); data_q.delete(); len_q.delete(); rise_q.delete();
    busy_cnt = 0;
  endtask

  task automatic frame(output int c0);
    @(negedge clk);
    vblank = 1'b1;
    c0 = cyc;
    repeat (2) @(negedge clk);
    vblank = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] d0, input logic [31:0] d1);
    check({tag, "_nwrites"}, 32'(addr_q.size()), 32'd2);
    if (addr_q.size() >= 2) begin
      check({tag, "_addr0"}, 32'(addr_q[0]), 32'd0);
      check({tag, "_data0"}, data_q[0], d0);
      check({tag, "_addr1"}, 32'(addr_q[1]), 32'd1);
      check({tag, "_data1"}, data_q[1], d1);
    end
    $display("frame %s: %0d writes", tag, addr_q.size());
  endtask

  initial begin
    int c0;
    repeat (3) @(negedge clk);
    check("rst_write", 32'(bus.cpu_write), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_addr", 32'(bus.cpu_oam_addr), 32'd0);
    check("rst_data", bus.cpu_oam_data, 32'd0);
    reset_n = 1'b1;

    // Single update; the write to index 2 is out of range and must vanish.
    cfg(6'd0, 32'h01050064, 8'h10);
    cfg(6'd1, 32'h01050AF0, 8'h00);
    cfg(6'd2, 32'hFFFFFFFF, 8'h77);
    clear_mon();
    frame(c0);
    check_frame("single", 32'h01050164, 32'h01050AF0);
    if (len_q.size() >= 2) begin
      check("single_len0", 32'(len_q[0]), 32'd2);
      check("single_len1", 32'(len_q[1]), 32'd2);
    end
    if (rise_q.size() >= 2) begin
      check("single_first_rise", 32'(rise_q[0] - c0), 32'd5);
      check("single_spacing", 32'(rise_q[1] - rise_q[0]), 32'd5);
    end
    check("single_busy_len", 32'(busy_cnt), 32'd10);
    check("single_frame_count", 32'(frame_count), 32'd1);
    check("single_overrun", 32'(overrun), 32'd0);

    // Edge handling: entry0 y=224/dy=+1, x=248/dx=+7; entry1 y=0/dy=-2, x=0/dx=-1.
    cfg(6'd0, 32'h0000E0F8, 8'h17);
    cfg(6'd1, 32'h00000000, 8'hEF);
    clear_mon();
    frame(c0);
`ifdef OAM_SEQ_BOUNCE_EN
    check_frame("edge1", 32'h0000E0F8, 32'h00000000);
`else
    check_frame("edge1", 32'h00000006, 32'h0000DFF8);
`endif
    clear_mon();
    frame(c0);
`ifdef OAM_SEQ_BOUNCE_EN
    check_frame("edge2", 32'h0000DFF1, 32'h00000201);
`else
    check_frame("edge2", 32'h0000010D, 32'h0000DDF7);
`endif
    check("edge_frame_count", 32'(frame_count), 32'd3);

    // cfg hits index 1 exactly in its LOAD cycle.
    cfg(6'd0, 32'h00000000, 8'h00);
    cfg(6'd1, 32'h00000A00, 8'h10);
    clear_mon();
    @(negedge clk);
    vblank = 1'b1;
    repeat (2) @(negedge clk);
    vblank = 1'b0;
    repeat (7) @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 6'd1; cfg_data = 32'h00003200; cfg_vel = 8'h00;
    @(negedge clk);
    cfg_we = 1'b0;
    repeat (20) @(negedge clk);
    check_frame("collide", 32'h00000000, 32'h00000B00);
    clear_mon();
    frame(c0);
    check_frame("collide_next", 32'h00000000, 32'h00003200);
    check("collide_frame_count", 32'(frame_count), 32'd5);

    // Second vblank rise lands while the frame is still being streamed.
    clear_mon();
    @(negedge clk);
    vblank = 1'b1;
    repeat (2) @(negedge clk);
    vblank = 1'b0;
    repeat (2) @(negedge clk);
    vblank = 1'b1;
    repeat (2) @(negedge clk);
    vblank = 1'b0;
    repeat (25) @(negedge clk);
    check("overrun_flag", 32'(overrun), 32'd1);
    check("overrun_frame_count", 32'(frame_count), 32'd6);
    check("overrun_nwrites", 32'(addr_q.size()), 32'd2);
    $display("overrun: overrun=%0d frame_count=%0d writes=%0d", overrun, frame_count, addr_q.size());

    // Reset in the middle of the first write pulse.
    cfg(6'd0, 32'h01020304, 8'h00);
    clear_mon();
    @(negedge clk);
    vblank = 1'b1;
    repeat (2) @(negedge clk);
    vblank = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_assert_write", 32'(bus.cpu_write), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_async_write", 32'(bus.cpu_write), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_overrun", 32'(overrun), 32'd0);
    check("rst_async_frame_count", 32'(frame_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_mon();
    frame(c0);
    check_frame("post_reset", 32'h00000000, 32'h00000000);
    check("post_reset_frame_count", 32'(frame_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
